demux_1to2_reg: RTL

Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2-to-1 data-flow mux. It accepts one `width`-bit word per valid/ready handshake on its input and steers it by `in_sel` into one of two output slots. Each output slot is independently back-pressured. The block sits between a single producer and two consumers in the data-routing path, and keeps a per-output transfer count for debug.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_out_slot.sv | 78 +++++++
 rtl/demux_1to2_reg.sv | 92 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the registered 1-to-2 stream demultiplexer.
//   SEL_A / SEL_B  : values of in_sel that select output A or output B
//   slot_state_t   : state of one output slot (EMPTY = valid low, FULL = valid high)
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// ---------------------------------------------------------------------------
// demux_out_slot
// One output register slot of the demultiplexer, plus its delivered-word
// counter. The slot is a two-state FSM: it fills on load and empties on an
// output handshake, unless it is reloaded in that same cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   write data_in into the slot this cycle (caller guarantees
//                 the slot is empty or draining)
//   data_in  in   word to load
//   ready    in   consumer takes the word held in the slot
//   valid    out  slot is FULL
//   data     out  held word; keeps its last value after draining
//   count    out  number of output handshakes, wraps at 2^cnt_width
// ---------------------------------------------------------------------------
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int width     = 64,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [width-1:0]     data_in,
    input  logic                 ready,
    output logic                 valid,
    output logic [width-1:0]     data,
    output logic [cnt_width-1:0] count
);

    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    slot_state_t state;
    logic        drain;

    // valid is the state register itself, so it is glitch-free and registered.
    assign valid = (state == SLOT_FULL);
    assign drain = valid && ready;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // The data register is reset as well: its zero value is visible
            // on the port right after reset, and a held word must be discarded.
            state <= SLOT_EMPTY;
            data  <= '0;
            count <= '0;
        end else begin
            unique case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        data  <= data_in;
                    end
                end
                SLOT_FULL: begin
                    // Drain and reload in the same cycle keeps the slot FULL
                    // with the new word, so valid never drops in streaming.
                    if (load) begin
                        data <= data_in;
                    end else if (ready) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase

            if (drain) begin
                count <= count + CNT_ONE;
            end
        end
    end

endmodule : demux_out_slot

// File: rtl/demux_1to2_reg.sv
// ---------------------------------------------------------------------------
// demux_1to2_reg
// Registered 1-to-2 stream demultiplexer. One word per valid/ready handshake
// on the input is steered by in_sel into output slot A or B. Each slot is
// back-pressured independently and counts the words it delivers.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_data/valid/sel   input word, word present, destination (0 = A, 1 = B)
//   in_ready            out: selected slot can take a word this cycle
//   a_data/a_valid      output A word and slot-full flag; a_ready from consumer A
//   b_data/b_valid      output B word and slot-full flag; b_ready from consumer B
//   a_count/b_count     words delivered on A / B, wrapping
// ---------------------------------------------------------------------------
module demux_1to2_reg
    import demux_pkg::*;
#(
    parameter int width     = 64,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_sel,
    output logic                 in_ready,
    output logic [width-1:0]     a_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [width-1:0]     b_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [cnt_width-1:0] a_count,
    output logic [cnt_width-1:0] b_count
);

    logic slot_free_a;
    logic slot_free_b;
    logic load_a;
    logic load_b;

    // A slot can take a word if it is empty or is being drained this cycle.
    assign slot_free_a = !a_valid || a_ready;
    assign slot_free_b = !b_valid || b_ready;

    // in_ready depends only on in_sel and the slot state, never on in_valid,
    // so a producer may legally wait for in_ready before raising in_valid.
    assign in_ready = (in_sel == SEL_B) ? slot_free_b : slot_free_a;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_a = 1'b0;
        load_b = 1'b0;
        if (in_valid && in_ready) begin
            if (in_sel == SEL_A) begin
                load_a = 1'b1;
            end else begin
                load_b = 1'b1;
            end
        end
    end

    demux_out_slot #(
        .width     (width),
        .cnt_width (cnt_width)
    ) u_slot_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_a),
        .data_in (in_data),
        .ready   (a_ready),
        .valid   (a_valid),
        .data    (a_data),
        .count   (a_count)
    );

    demux_out_slot #(
        .width     (width),
        .cnt_width (cnt_width)
    ) u_slot_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_b),
        .data_in (in_data),
        .ready   (b_ready),
        .valid   (b_valid),
        .data    (b_data),
        .count   (b_count)
    );

endmodule : demux_1to2_reg
